// File: rtl/spi_pkg.sv
// Shared SPI definitions: data width, mode encodings and CPOL/CPHA decode.
// Used by the responder and by the SCLK generator on the master side.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_SELECT
    } spi_state_t;

    function automatic logic cpol(input logic [1:0] m);
        return m[1];
    endfunction

    function automatic logic cpha(input logic [1:0] m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Parallel byte exchange between the SPI responder and local logic.
interface spi_slave_if;
    import spi_pkg::*;

    logic [SPI_DATA_W-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic [SPI_DATA_W-1:0] rx_data;
    logic                  rx_valid;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_underrun, rx_data, rx_valid
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_underrun, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall pulses
// derived from one extra history flop.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/SS_n/MOSI, byte-wide shift in and out,
// one-deep transmit buffer and a receive strobe. All four SPI modes.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [1:0] mode = MODE3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SCLK,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    output logic       busy,
    spi_slave_if.slave bus
);
    localparam logic CPOL  = cpol(mode);
    localparam logic CPHA  = cpha(mode);
    localparam int   CNT_W = $clog2(SPI_DATA_W);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_ss_q, w_ss_rise, w_ss_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .i_d(SCLK),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .i_d(SS_n),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .i_d(MOSI),
        .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    assign w_unused = ^{w_sclk_q, w_ss_q, w_mosi_rise, w_mosi_fall};

    logic w_lead, w_trail, w_sample, w_shift;
    assign w_lead   = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead  : w_trail;

    spi_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [SPI_DATA_W-2:0] r_rx_shift;
    logic [SPI_DATA_W-1:0] r_tx_shift, r_buf, r_rx_data;
    logic                  r_buf_full, r_rx_valid, r_underrun;
    logic                  r_byte_done, r_hold_first;
    logic                  w_start, w_samp_en, w_shift_en, w_desel, w_first_clr;
    logic [SPI_DATA_W-1:0] w_rx_next;

    assign w_rx_next = {r_rx_shift, w_mosi};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // A shift edge that follows the 8th sample loads the next byte instead of
    // shifting; with CPHA=1 the first leading edge of a frame only exposes bit 7.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_samp_en   = 1'b0;
        w_shift_en  = 1'b0;
        w_desel     = 1'b0;
        w_first_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_SELECT;
                    w_start     = 1'b1;
                end
            end
            ST_SELECT: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_desel     = 1'b1;
                end else begin
                    w_samp_en = w_sample;
                    if (w_shift) begin
                        if (r_byte_done) begin
                            w_start = 1'b1;
                        end else begin
                            w_first_clr = 1'b1;
                            w_shift_en  = !(CPHA && r_hold_first);
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_buf        <= '0;
            r_buf_full   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_underrun   <= 1'b0;
            r_byte_done  <= 1'b0;
            r_hold_first <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            if (w_desel) begin
                r_bit_cnt    <= '0;
                r_rx_shift   <= '0;
                r_tx_shift   <= '0;
                r_byte_done  <= 1'b0;
                r_hold_first <= 1'b0;
            end
            if (w_samp_en) begin
                r_rx_shift <= w_rx_next[SPI_DATA_W-2:0];
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == CNT_W'(SPI_DATA_W - 1)) begin
                    r_rx_data   <= w_rx_next;
                    r_rx_valid  <= 1'b1;
                    r_byte_done <= 1'b1;
                end
            end
            if (w_shift_en)  r_tx_shift   <= {r_tx_shift[SPI_DATA_W-2:0], 1'b0};
            if (w_first_clr) r_hold_first <= 1'b0;
            if (w_start) begin
                r_byte_done  <= 1'b0;
                r_hold_first <= (r_state == ST_IDLE);
                if (r_state == ST_IDLE) r_bit_cnt <= '0;
                if (r_buf_full) begin
                    r_tx_shift <= r_buf;
                    r_buf_full <= 1'b0;
                end else begin
                    r_tx_shift <= '0;
                    r_underrun <= 1'b1;
                end
            end
            // Written after the consume so a same-cycle write survives for the next byte.
            if (bus.tx_valid && !r_buf_full) begin
                r_buf      <= bus.tx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    assign busy            = (r_state == ST_SELECT);
    assign miso_oe         = busy;
    assign MISO            = busy & r_tx_shift[SPI_DATA_W-1];
    assign bus.tx_ready    = !r_buf_full;
    assign bus.tx_underrun = r_underrun;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, an SPI master model driving
// the selected one, and a monitor scoring MISO bytes, rx bytes and underruns.
`timescale 1ns/1ps
module tb_spi_slave;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       sclk_act = 1'b0;
    logic [3:0] ss_n = '1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    int         cur = 0;

    logic [3:0] miso_a, oe_a, busy_a, ready_a, unr_a, rxv_a;
    logic [7:0] rxd_a [4];

    spi_slave_if ifc [4] ();

    for (genvar m = 0; m < 4; m++) begin : g_dut
        logic w_sclk;
        assign w_sclk          = sclk_act ^ cpol(2'(m));
        assign ifc[m].tx_data  = tx_data;
        assign ifc[m].tx_valid = tx_valid && (cur == m);
        spi_slave #(.mode(2'(m))) u_dut (
            .clk(clk), .reset_n(reset_n), .SCLK(w_sclk), .SS_n(ss_n[m]),
            .MOSI(mosi), .MISO(miso_a[m]), .miso_oe(oe_a[m]), .busy(busy_a[m]),
            .bus(ifc[m].slave)
        );
        assign ready_a[m] = ifc[m].tx_ready;
        assign unr_a[m]   = ifc[m].tx_underrun;
        assign rxv_a[m]   = ifc[m].rx_valid;
        assign rxd_a[m]   = ifc[m].rx_data;
    end

    // Scoreboard state
    int         errors = 0, checks = 0, timeouts = 0;
    int         exp_unr = 0, got_unr = 0;
    logic [7:0] exp_rx[$], exp_miso[$];
    bit         bq_full[4] = '{default: 1'b0};
    logic [7:0] bq_val[4];
    bit         done = 1'b0, mon_done = 1'b0;

    initial begin : monitor
        int         hi_cnt, lo_cnt, nb;
        logic       prev_act;
        logic [7:0] sh, e;
        hi_cnt = 0; lo_cnt = 0; nb = 0; prev_act = 1'b0; sh = '0;
        while (!done) begin
            @(negedge clk);
            if (!reset_n) begin
                checks++;
                if ({miso_a, oe_a, busy_a, ready_a, unr_a, rxv_a} != {16'h000F, 8'h00} ||
                    (rxd_a[0] | rxd_a[1] | rxd_a[2] | rxd_a[3]) != 8'h00) begin
                    errors++;
                    $display("FAIL reset_vals: got miso=%b oe=%b busy=%b rdy=%b unr=%b rxv=%b rxd0=%02h expected 0,0,0,1111,0,0,00",
                             miso_a, oe_a, busy_a, ready_a, unr_a, rxv_a, rxd_a[0]);
                end
                hi_cnt = 0; lo_cnt = 0; nb = 0;
            end else begin
                if (rxv_a[cur]) begin
                    checks++;
                    if (exp_rx.size() == 0) begin
                        errors++;
                        $display("FAIL rx_extra: got rx_data=%02h expected no rx_valid", rxd_a[cur]);
                    end else begin
                        e = exp_rx.pop_front();
                        if (rxd_a[cur] !== e) begin
                            errors++;
                            $display("FAIL rx_data: mode %0d got %02h expected %02h", cur, rxd_a[cur], e);
                        end
                    end
                end
                if (unr_a[cur]) got_unr++;
                if (ss_n[cur]) begin hi_cnt++; lo_cnt = 0; end
                else           begin lo_cnt++; hi_cnt = 0; end
                if (hi_cnt == 5) begin
                    checks++;
                    if ({busy_a[cur], oe_a[cur], miso_a[cur]} !== 3'b000) begin
                        errors++;
                        $display("FAIL idle_outs: got busy/oe/miso=%b expected 000",
                                 {busy_a[cur], oe_a[cur], miso_a[cur]});
                    end
                end
                if (lo_cnt == 5) begin
                    checks++;
                    if ({busy_a[cur], oe_a[cur]} !== 2'b11) begin
                        errors++;
                        $display("FAIL select_outs: got busy/oe=%b expected 11", {busy_a[cur], oe_a[cur]});
                    end
                end
                if (ss_n[cur]) begin
                    nb = 0;
                end else if (sclk_act != prev_act && sclk_act == !cpha(2'(cur))) begin
                    sh = {sh[6:0], miso_a[cur]};
                    nb++;
                    if (nb == 8) begin
                        nb = 0;
                        checks++;
                        if (exp_miso.size() == 0) begin
                            errors++;
                            $display("FAIL miso_extra: got byte %02h expected none", sh);
                        end else begin
                            e = exp_miso.pop_front();
                            if (sh !== e) begin
                                errors++;
                                $display("FAIL miso_byte: mode %0d got %02h expected %02h", cur, sh, e);
                            end
                        end
                    end
                end
            end
            prev_act = sclk_act;
        end
        checks++;
        if (exp_rx.size() != 0 || exp_miso.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d rx / %0d miso bytes outstanding expected 0/0",
                     exp_rx.size(), exp_miso.size());
        end
        checks++;
        if (got_unr != exp_unr) begin
            errors++;
            $display("FAIL underrun_count: got %0d expected %0d", got_unr, exp_unr);
        end
        checks++;
        if (timeouts != 0) begin
            errors++;
            $display("FAIL handshake_timeouts: got %0d expected 0", timeouts);
        end
        mon_done = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic half();
        wait_clk(8);
    endtask

    // Reference: a byte start takes the buffered byte if present, else sends 0x00 and underruns.
    task automatic model_start(output logic [7:0] e);
        if (bq_full[cur]) begin
            e = bq_val[cur];
            bq_full[cur] = 1'b0;
        end else begin
            e = 8'h00;
            exp_unr++;
        end
    endtask

    task automatic write_tx(input logic [7:0] d);
        int n;
        n = 0;
        while (!ready_a[cur] && n < 64) begin wait_clk(1); n++; end
        if (!ready_a[cur]) begin
            timeouts++;
            $display("FAIL tx_ready_wait: got tx_ready=0 after 64 cycles expected 1");
        end else begin
            tx_valid = 1'b1; tx_data = d;
            wait_clk(1);
            tx_valid = 1'b0;
            bq_val[cur] = d; bq_full[cur] = 1'b1;
        end
    endtask

    task automatic frame(input int nb, input logic [7:0] mo[4], input logic [7:0] nx[4],
                         input bit sup[4], input bit race, input logic [7:0] race_d,
                         input int abort_bits);
        logic [7:0] e;
        bit         ph, abort_k;
        int         nbits;
        ph = cpha(2'(cur));
        ss_n[cur] = 1'b0;
        model_start(e);
        if (race) begin
            wait_clk(2);
            tx_valid = 1'b1; tx_data = race_d;
            wait_clk(1);
            tx_valid = 1'b0;
            bq_val[cur] = race_d; bq_full[cur] = 1'b1;
            wait_clk(5);
        end else begin
            wait_clk(8);
        end
        for (int k = 0; k < nb; k++) begin
            abort_k = (abort_bits > 0) && (k == nb - 1);
            nbits   = abort_k ? abort_bits : 8;
            if (k > 0 && ph) model_start(e);
            if (!abort_k) begin
                exp_miso.push_back(e);
                exp_rx.push_back(mo[k]);
            end
            for (int i = 7; i >= 8 - nbits; i--) begin
                if (!ph) begin
                    mosi = mo[k][i]; half();
                    sclk_act = 1'b1; half();
                    if (i == 7 && sup[k]) write_tx(nx[k]);
                    sclk_act = 1'b0;
                end else begin
                    sclk_act = 1'b1; mosi = mo[k][i]; half();
                    if (i == 7 && sup[k]) write_tx(nx[k]);
                    sclk_act = 1'b0; half();
                end
            end
            if (!abort_k && !ph) model_start(e);
        end
        half();
        ss_n[cur] = 1'b1;
        wait_clk(24);
    endtask

    initial begin : stimulus
        logic [7:0] mo[4], nx[4], e;
        bit         sup[4];
        int         nb, ab, n;
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(10);

        cur = 3; write_tx(8'hA5);
        frame(1, '{8'h3C, 8'h00, 8'h00, 8'h00}, '{default: 8'h00}, '{default: 1'b0}, 1'b0, 8'h00, 0);
        for (int m = 0; m < 3; m++) begin
            cur = m; write_tx(8'h5A);
            frame(1, '{8'hC3, 8'h00, 8'h00, 8'h00}, '{default: 8'h00}, '{default: 1'b0}, 1'b0, 8'h00, 0);
        end
        cur = 0; write_tx(8'h11);
        frame(2, '{8'hE7, 8'h18, 8'h00, 8'h00}, '{8'h22, 8'h00, 8'h00, 8'h00},
              '{1'b1, 1'b0, 1'b0, 1'b0}, 1'b0, 8'h00, 0);
        frame(2, '{8'h42, 8'h24, 8'h00, 8'h00}, '{default: 8'h00}, '{default: 1'b0}, 1'b1, 8'h6B, 0);
        cur = 3;
        frame(2, '{8'h99, 8'h66, 8'h00, 8'h00}, '{default: 8'h00}, '{default: 1'b0}, 1'b1, 8'hD2, 0);
        cur = 1; write_tx(8'hF0);
        frame(1, '{8'hFF, 8'h00, 8'h00, 8'h00}, '{default: 8'h00}, '{default: 1'b0}, 1'b0, 8'h00, 5);
        write_tx(8'h3E);
        frame(1, '{8'h81, 8'h00, 8'h00, 8'h00}, '{default: 8'h00}, '{default: 1'b0}, 1'b0, 8'h00, 0);

        for (int r = 0; r < 24; r++) begin
            cur = $urandom_range(0, 3);
            nb  = $urandom_range(1, 3);
            ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 4; k++) begin
                mo[k]  = 8'($urandom);
                nx[k]  = 8'($urandom);
                sup[k] = ($urandom_range(0, 3) != 0);
            end
            if (!bq_full[cur] && $urandom_range(0, 1) == 1) write_tx(8'($urandom));
            frame(nb, mo, nx, sup, 1'b0, 8'h00, ab);
        end

        cur = 2; write_tx(8'h77);
        ss_n[2] = 1'b0; model_start(e);
        wait_clk(8);
        mosi = 1'b1; half();
        sclk_act = 1'b1; half();
        write_tx(8'h99);
        sclk_act = 1'b0; half();
        sclk_act = 1'b1; wait_clk(3);
        reset_n = 1'b0;
        wait_clk(4);
        ss_n[2] = 1'b1; sclk_act = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        bq_full = '{default: 1'b0};
        wait_clk(16);
        cur = 0; write_tx(8'hC9);
        frame(1, '{8'h5D, 8'h00, 8'h00, 8'h00}, '{default: 8'h00}, '{default: 1'b0}, 1'b0, 8'h00, 0);

        done = 1'b1;
        n = 0;
        while (!mon_done && n < 100) begin wait_clk(1); n++; end
        if (!mon_done) begin
            $display("FAIL monitor_finish: got no final checks expected completion");
            $fatal(1, "monitor did not finish");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder: the far end of the SPI link whose master side generates SCLK in the `clk` domain. Oversamples SCLK, SS_n and MOSI with the system clock, shifts a byte out on MISO while shifting a byte in from MOSI, and exchanges parallel bytes with local logic over a one-deep transmit buffer and a receive strobe. Supports all four SPI modes and back-to-back bytes within one SS_n frame.

## Interface
- `mode`, default 2'b11: SPI mode. CPOL = mode[1] (SCLK idle level). CPHA = mode[0] (0: sample on leading edge; 1: sample on trailing edge).
- `clk` input 1: system clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `SCLK` input 1: serial clock from master, asynchronous to `clk`.
- `SS_n` input 1: slave select, active low, asynchronous.
- `MOSI` input 1: master-out data, MSB first.
- `MISO` output 1: slave-out data, MSB first; 0 when deselected.
- `miso_oe` output 1: MISO output enable; high while selected (pad tri-state control).
- `tx_data` input 8: byte to transmit.
- `tx_valid` input 1: tx_data offered.
- `tx_ready` output 1: transmit buffer empty; byte accepted when `tx_valid && tx_ready`.
- `tx_underrun` output 1: one-cycle pulse, byte started with empty buffer.
- `rx_data` output 8: last complete received byte; held until next byte.
- `rx_valid` output 1: one-cycle pulse, rx_data updated.
- `busy` output 1: high while selected.

## Operation
- SCLK, SS_n, MOSI each pass a 2-flop synchronizer; SCLK and SS_n get a registered edge detector. Leading edge = SCLK leaves CPOL level; trailing = returns to it.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge: the other edge.
- States: IDLE, SELECT.
- IDLE: MISO=0, miso_oe=0, busy=0. Synchronized SS_n falling -> SELECT, bit_cnt=0, byte start.
- Byte start: buffer full -> tx_shift <= buffer, buffer empties (tx_ready rises next cycle). Buffer empty -> tx_shift <= 8'h00, tx_underrun pulse. MISO = tx_shift[7] continuously while selected.
- Sample edge: rx_shift <= {rx_shift[6:0], MOSI_sync}; bit_cnt++. On 8th sample (bit_cnt wraps 7->0): rx_data <= completed byte, rx_valid pulse.
- Shift edge: tx_shift <= tx_shift<<1, except: CPHA=1 first leading edge of a byte does not shift; CPHA=0 trailing edge after 8th sample performs byte start instead of a shift; CPHA=1 leading edge after 8th sample performs byte start.
- Synchronized SS_n rising -> IDLE from any point: partial rx byte discarded (no rx_valid), bit_cnt=0, in-flight tx byte lost, buffer untouched.
- No rx backpressure; consumer must take rx_data on rx_valid.

## Timing
- Reset values: MISO 0, miso_oe 0, tx_ready 1, tx_underrun 0, rx_data 8'h00, rx_valid 0, busy 0; all shift regs, bit_cnt, buffer cleared; state IDLE.
- Pin-to-action latency: 3 clk (2 sync + 1 edge detect). MISO changes 4 clk after the pin edge; rx_valid asserts 4 clk after the 8th sample pin edge.
- Requirement: SCLK half-period >= 6 clk; SS_n fall to first SCLK edge >= 6 clk. Master at /16 (half-period 8) satisfies this.
- Buffer write and byte-start consume in same cycle: consume sees pre-write state (empty -> underrun, 0x00 sent); written byte stays for next byte.
- SS_n rise and sample edge in same cycle: deselect wins.
- Reset mid-frame: immediate return to reset values.

## Structure
- Shared package `spi_pkg`: mode constants (MODE0..MODE3), functions cpol(mode)/cpha(mode), `SPI_DATA_W = 8`; reuse in the SCLK generator.
- Sub-module `spi_sync_edge`: 2-flop synchronizer with reset value parameter plus rise/fall pulses; instanced for SCLK (reset to CPOL), SS_n (reset 1), MOSI (sync only).

## Test plan
- Mode 3, write tx 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1 at master rising edges; rx_valid once, rx_data=0x3C.
- Modes 0,1,2 each: same exchange 0x5A/0xC3 -> correct bits both directions, one rx_valid per byte.
- Mode 0, two bytes one frame, tx 0x11 then 0x22 loaded while tx_ready -> MISO 0x11,0x22; rx_valid twice; no underrun.
- Empty buffer at frame start -> tx_underrun pulse, MISO 0x00; tx_valid same cycle -> byte sent as next byte.
- SS_n raised after 5 bits -> no rx_valid, bit_cnt 0; next frame with 0x81 received correctly.
- reset_n low mid-byte -> all outputs at reset values within the same cycle; tx_ready=1.
